// File: rtl/ram_dma.sv
// Byte-serial DMA sequencer for a 2^ADDR_W x DATA_W synchronous RAM: COPY (read then write per byte)
// and FILL. Every RAM strobe and status output is driven directly from a flop.
module ram_dma #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aborted,
    output logic [DATA_W-1:0] checksum,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_read_addr,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_read_data
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(1) << ADDR_W;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(RD_LAT - 1);

    if (RD_LAT < 1) begin : g_lat_check
        $error("RD_LAT must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StWr,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              aborted_q, aborted_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              ram_read_q, ram_read_d;
    logic              ram_write_q, ram_write_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [IDX_W-1:0]  idx_nxt;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        fill_d     = fill_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        error_d    = error_q;
        aborted_d  = aborted_q;
        checksum_d = checksum_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        idx_nxt    = idx_q + IDX_ONE;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d     = mode;
                    src_d      = src_addr;
                    dst_d      = dst_addr;
                    len_d      = length;
                    fill_d     = fill_data;
                    idx_d      = '0;
                    checksum_d = '0;
                    error_d    = 1'b0;
                    aborted_d  = 1'b0;
                    if (length > MAX_LEN) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else if (length == '0) begin
                        state_d = StDone;
                    end else if (mode) begin
                        state_d   = StWr;
                        wr_addr_d = dst_addr;
                        wr_data_d = fill_data;
                    end else begin
                        state_d   = StRd;
                        rd_addr_d = src_addr;
                    end
                end
            end
            StRd: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    wcnt_d  = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else if (wcnt_q == LAST_WAIT) begin
                    state_d   = StWr;
                    wr_addr_d = dst_q + idx_q[ADDR_W-1:0];
                    wr_data_d = ram_read_data;
                end else begin
                    wcnt_d = wcnt_q + CNT_ONE;
                end
            end
            StWr: begin
                // The write on the bus this cycle lands regardless of abort, so always count it.
                checksum_d = checksum_q + wr_data_q;
                idx_d      = idx_nxt;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else if (idx_nxt == len_q) begin
                    state_d = StDone;
                end else if (mode_q) begin
                    wr_addr_d = dst_q + idx_nxt[ADDR_W-1:0];
                    wr_data_d = fill_q;
                end else begin
                    rd_addr_d = src_q + idx_nxt[ADDR_W-1:0];
                    state_d   = StRd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Strobes are a decode of the next state so they appear registered with the state.
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        ram_read_d  = (state_d == StRd);
        ram_write_d = (state_d == StWr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            fill_q      <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            aborted_q   <= 1'b0;
            checksum_q  <= '0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            fill_q      <= fill_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            aborted_q   <= aborted_d;
            checksum_q  <= checksum_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign aborted        = aborted_q;
    assign checksum       = checksum_q;
    assign ram_read       = ram_read_q;
    assign ram_write      = ram_write_q;
    assign ram_read_addr  = rd_addr_q;
    assign ram_write_addr = wr_addr_q;
    assign ram_write_data = wr_data_q;

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: a behavioural 16x8 RAM plus a sequential byte-by-byte reference model.
module tb_ram_dma;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;

    logic       clock = 1'b0;
    logic       reset, start, mode, abort;
    logic [3:0] src_addr, dst_addr;
    logic [4:0] length;
    logic [7:0] fill_data;
    logic       busy, done, error, aborted, ram_read, ram_write;
    logic [7:0] checksum, ram_write_data;
    logic [7:0] ram_read_data;
    logic [3:0] ram_read_addr, ram_write_addr;

    logic [7:0] mem       [DEPTH];
    logic [7:0] init_mem  [DEPTH];
    logic [7:0] model_mem [DEPTH];
    logic       load = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int n_busy = 0, n_done = 0, n_wr = 0, n_rd = 0;
    int b0, d0, w0, r0;

    always #5 clock = ~clock;

    ram_dma #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .mode          (mode),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .length        (length),
        .fill_data     (fill_data),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .aborted       (aborted),
        .checksum      (checksum),
        .ram_read      (ram_read),
        .ram_write     (ram_write),
        .ram_read_addr (ram_read_addr),
        .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data),
        .ram_read_data (ram_read_data)
    );

    always @(posedge clock) begin
        if (load) begin
            mem <= init_mem;
        end else begin
            if (ram_write) mem[ram_write_addr] <= ram_write_data;
            if (ram_read) ram_read_data <= mem[ram_read_addr];
        end
    end

    always @(negedge clock) begin
        if (busy === 1'b1) n_busy <= n_busy + 1;
        if (done === 1'b1) n_done <= n_done + 1;
        if (ram_write === 1'b1) n_wr <= n_wr + 1;
        if (ram_read === 1'b1) n_rd <= n_rd + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, busy=%0b", busy);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic randomize_init();
        for (int k = 0; k < DEPTH; k++) init_mem[k] = 8'($urandom);
    endtask

    task automatic load_mem();
        for (int k = 0; k < DEPTH; k++) model_mem[k] = init_mem[k];
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic snap();
        b0 = n_busy;
        d0 = n_done;
        w0 = n_wr;
        r0 = n_rd;
    endtask

    task automatic issue(input logic m, input logic [3:0] s, input logic [3:0] d,
                         input logic [4:0] l, input logic [7:0] f);
        mode      = m;
        src_addr  = s;
        dst_addr  = d;
        length    = l;
        fill_data = f;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        for (int k = 0; k < 200 && busy === 1'b1; k++) tick();
        timed_out = (busy !== 1'b0);
    endtask

    // Reference: bytes move one at a time in index order, at most nmax of them.
    task automatic model_cmd(input logic m, input logic [3:0] s, input logic [3:0] d,
                             input logic [4:0] l, input logic [7:0] f, input int nmax,
                             output logic [7:0] ck);
        logic [7:0] b;
        ck = 8'h00;
        if (l <= 5'd16) begin
            for (int k = 0; k < int'(l) && k < nmax; k++) begin
                b = m ? f : model_mem[s + 4'(k)];
                model_mem[d + 4'(k)] = b;
                ck = ck + b;
            end
        end
    endtask

    function automatic int exp_busy(input logic m, input logic [4:0] l);
        if (l == 5'd0 || l > 5'd16) return 1;
        return m ? int'(l) + 1 : 3 * int'(l) + 1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mode = 1'b1; abort = 1'b0;
        src_addr = 4'd0; dst_addr = 4'd2; length = 5'd4; fill_data = 8'h3C;
        tick();
        tick();
        vectors++;
        if ({busy, done, error, aborted, checksum, ram_read, ram_write, ram_read_addr,
             ram_write_addr, ram_write_data} !== '0)
            begin miscompares++; $display("FAIL reset_outputs: busy=%0b done=%0b wr=%0b rd=%0b ck=%h, required all 0",
                busy, done, ram_write, ram_read, checksum); end
        reset = 1'b0;
        start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_wins_start: busy=%0b, required 0", busy); end
    endtask

    task automatic test_fill();
        bit to;
        logic [7:0] ck;
        randomize_init();
        load_mem();
        snap();
        model_cmd(1'b1, 4'd0, 4'd3, 5'd4, 8'hA5, 99, ck);
        issue(1'b1, 4'd0, 4'd3, 5'd4, 8'hA5);
        wait_idle(to);
        vectors++; if (to) begin miscompares++; $display("FAIL fill_timeout: busy stuck at %0b, required 0", busy); end
        vectors++; if (n_busy - b0 !== 5) begin miscompares++; $display("FAIL fill_busy_cycles: got %0d, required 5", n_busy - b0); end
        vectors++; if (n_done - d0 !== 1) begin miscompares++; $display("FAIL fill_done_pulses: got %0d, required 1", n_done - d0); end
        vectors++; if (checksum !== 8'h94) begin miscompares++; $display("FAIL fill_checksum: got %h, required 94", checksum); end
        vectors++; if (n_wr - w0 !== 4 || n_rd - r0 !== 0) begin miscompares++;
            $display("FAIL fill_strobes: writes %0d reads %0d, required 4 and 0", n_wr - w0, n_rd - r0); end
        vectors++; if (error !== 1'b0 || aborted !== 1'b0) begin miscompares++;
            $display("FAIL fill_flags: error %0b aborted %0b, required 0 0", error, aborted); end
        for (int k = 0; k < DEPTH; k++) begin
            vectors++;
            if (mem[k] !== model_mem[k]) begin miscompares++;
                $display("FAIL fill_mem[%0d]: got %h, required %h", k, mem[k], model_mem[k]); end
        end
    endtask

    task automatic test_copy();
        bit to;
        logic [7:0] ck;
        randomize_init();
        init_mem[0] = 8'h01; init_mem[1] = 8'h02; init_mem[2] = 8'hFF;
        load_mem();
        snap();
        model_cmd(1'b0, 4'd0, 4'd8, 5'd3, 8'h00, 99, ck);
        issue(1'b0, 4'd0, 4'd8, 5'd3, 8'h00);
        wait_idle(to);
        vectors++; if (to) begin miscompares++; $display("FAIL copy_timeout: busy stuck at %0b, required 0", busy); end
        vectors++; if (n_busy - b0 !== 10) begin miscompares++; $display("FAIL copy_busy_cycles: got %0d, required 10", n_busy - b0); end
        vectors++; if (checksum !== 8'h02) begin miscompares++; $display("FAIL copy_checksum: got %h, required 02", checksum); end
        vectors++; if (n_rd - r0 !== 3 || n_wr - w0 !== 3) begin miscompares++;
            $display("FAIL copy_strobes: reads %0d writes %0d, required 3 and 3", n_rd - r0, n_wr - w0); end
        vectors++; if ({mem[8], mem[9], mem[10]} !== 24'h0102FF) begin miscompares++;
            $display("FAIL copy_dst: got %h%h%h, required 0102ff", mem[8], mem[9], mem[10]); end
        for (int k = 0; k < DEPTH; k++) begin
            vectors++;
            if (mem[k] !== model_mem[k]) begin miscompares++;
                $display("FAIL copy_mem[%0d]: got %h, required %h", k, mem[k], model_mem[k]); end
        end
    endtask

    task automatic test_wrap_overlap();
        bit to;
        logic [7:0] ck, old0, old14, old15;
        randomize_init();
        load_mem();
        old0 = init_mem[0]; old14 = init_mem[14]; old15 = init_mem[15];
        model_cmd(1'b0, 4'd14, 4'd1, 5'd4, 8'h00, 99, ck);
        issue(1'b0, 4'd14, 4'd1, 5'd4, 8'h00);
        wait_idle(to);
        vectors++; if (to) begin miscompares++; $display("FAIL wrap_timeout: busy stuck at %0b, required 0", busy); end
        vectors++; if ({mem[1], mem[2], mem[3], mem[4]} !== {old14, old15, old0, old14}) begin miscompares++;
            $display("FAIL wrap_dst: got %h %h %h %h, required %h %h %h %h",
                mem[1], mem[2], mem[3], mem[4], old14, old15, old0, old14); end
        vectors++; if (checksum !== ck) begin miscompares++; $display("FAIL wrap_checksum: got %h, required %h", checksum, ck); end

        init_mem[2] = 8'h5C;
        load_mem();
        model_cmd(1'b0, 4'd2, 4'd3, 5'd3, 8'h00, 99, ck);
        issue(1'b0, 4'd2, 4'd3, 5'd3, 8'h00);
        wait_idle(to);
        vectors++; if ({mem[3], mem[4], mem[5]} !== 24'h5C5C5C) begin miscompares++;
            $display("FAIL overlap_dst: got %h %h %h, required 5c 5c 5c", mem[3], mem[4], mem[5]); end
        vectors++; if (checksum !== 8'h14) begin miscompares++; $display("FAIL overlap_checksum: got %h, required 14", checksum); end
    endtask

    task automatic test_len0_error();
        bit to;
        snap();
        issue(1'b0, 4'd5, 4'd6, 5'd0, 8'h77);
        wait_idle(to);
        vectors++; if (to || n_busy - b0 !== 1 || n_done - d0 !== 1) begin miscompares++;
            $display("FAIL len0_timing: busy %0d done %0d, required 1 and 1", n_busy - b0, n_done - d0); end
        vectors++; if (n_wr - w0 !== 0 || n_rd - r0 !== 0 || error !== 1'b0) begin miscompares++;
            $display("FAIL len0_strobes: writes %0d reads %0d error %0b, required 0 0 0", n_wr - w0, n_rd - r0, error); end
        snap();
        issue(1'b1, 4'd0, 4'd0, 5'd17, 8'h77);
        wait_idle(to);
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL len17_error: got %0b, required 1", error); end
        vectors++; if (to || n_busy - b0 !== 1 || n_done - d0 !== 1) begin miscompares++;
            $display("FAIL len17_timing: busy %0d done %0d, required 1 and 1", n_busy - b0, n_done - d0); end
        vectors++; if (n_wr - w0 !== 0 || n_rd - r0 !== 0 || checksum !== 8'h00) begin miscompares++;
            $display("FAIL len17_strobes: writes %0d reads %0d ck %h, required 0 0 00", n_wr - w0, n_rd - r0, checksum); end
        tick(); tick();
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL error_hold: got %0b, required 1", error); end
    endtask

    task automatic test_abort();
        bit to;
        logic [7:0] ck, f;
        f = 8'($urandom);
        randomize_init();
        load_mem();
        snap();
        model_cmd(1'b1, 4'd0, 4'd5, 5'd8, f, 2, ck);
        issue(1'b1, 4'd0, 4'd5, 5'd8, f);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle(to);
        vectors++; if (to || n_wr - w0 !== 2) begin miscompares++; $display("FAIL abort_writes: got %0d, required 2", n_wr - w0); end
        vectors++; if (aborted !== 1'b1 || n_done - d0 !== 1) begin miscompares++;
            $display("FAIL abort_flags: aborted %0b done %0d, required 1 and 1", aborted, n_done - d0); end
        vectors++; if (checksum !== ck || n_busy - b0 !== 3) begin miscompares++;
            $display("FAIL abort_checksum: ck %h busy %0d, required %h and 3", checksum, n_busy - b0, ck); end
        for (int k = 0; k < DEPTH; k++) begin
            vectors++;
            if (mem[k] !== model_mem[k]) begin miscompares++;
                $display("FAIL abort_mem[%0d]: got %h, required %h", k, mem[k], model_mem[k]); end
        end
        snap();
        model_cmd(1'b1, 4'd0, 4'd12, 5'd2, f, 99, ck);
        abort = 1'b1;
        issue(1'b1, 4'd0, 4'd12, 5'd2, f);
        abort = 1'b0;
        wait_idle(to);
        vectors++; if (aborted !== 1'b0 || n_wr - w0 !== 2 || checksum !== ck) begin miscompares++;
            $display("FAIL abort_in_idle: aborted %0b writes %0d ck %h, required 0 2 %h", aborted, n_wr - w0, checksum, ck); end
    endtask

    task automatic test_start_ignored();
        bit to;
        logic [7:0] ck;
        randomize_init();
        load_mem();
        snap();
        model_cmd(1'b1, 4'd0, 4'd0, 5'd3, 8'h11, 99, ck);
        issue(1'b1, 4'd0, 4'd0, 5'd3, 8'h11);
        start = 1'b1; mode = 1'b1; dst_addr = 4'd9; length = 5'd2; fill_data = 8'h22;
        wait_idle(to);
        start = 1'b0;
        tick(); tick();
        vectors++; if (to || busy !== 1'b0 || n_done - d0 !== 1) begin miscompares++;
            $display("FAIL start_ignored_busy: busy %0b done %0d, required 0 and 1", busy, n_done - d0); end
        vectors++; if (n_wr - w0 !== 3 || n_busy - b0 !== 4) begin miscompares++;
            $display("FAIL start_ignored_writes: writes %0d busy %0d, required 3 and 4", n_wr - w0, n_busy - b0); end
        for (int k = 0; k < DEPTH; k++) begin
            vectors++;
            if (mem[k] !== model_mem[k]) begin miscompares++;
                $display("FAIL start_ignored_mem[%0d]: got %h, required %h", k, mem[k], model_mem[k]); end
        end
    endtask

    task automatic test_reset_mid();
        randomize_init();
        load_mem();
        snap();
        issue(1'b0, 4'd0, 4'd8, 5'd2, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if ({busy, done, error, aborted, checksum, ram_read, ram_write, ram_read_addr,
             ram_write_addr, ram_write_data} !== '0)
            begin miscompares++; $display("FAIL reset_mid_outputs: busy=%0b wr=%0b rd=%0b, required all 0",
                busy, ram_write, ram_read); end
        reset = 1'b0;
        tick(); tick(); tick();
        vectors++; if (n_wr - w0 !== 0 || n_done - d0 !== 0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL reset_mid_after: writes %0d done %0d busy %0b, required 0 0 0", n_wr - w0, n_done - d0, busy); end
        for (int k = 0; k < DEPTH; k++) begin
            vectors++;
            if (mem[k] !== model_mem[k]) begin miscompares++;
                $display("FAIL reset_mid_mem[%0d]: got %h, required %h", k, mem[k], model_mem[k]); end
        end
    endtask

    task automatic test_random();
        bit to;
        logic m;
        logic [3:0] s, d;
        logic [4:0] l;
        logic [7:0] f, ck;
        randomize_init();
        load_mem();
        for (int it = 0; it < 24; it++) begin
            m = 1'($urandom_range(0, 1));
            s = 4'($urandom);
            d = 4'($urandom);
            l = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            f = 8'($urandom);
            model_cmd(m, s, d, l, f, 99, ck);
            snap();
            issue(m, s, d, l, f);
            wait_idle(to);
            vectors++; if (to || n_busy - b0 !== exp_busy(m, l) || n_done - d0 !== 1) begin miscompares++;
                $display("FAIL rand%0d_timing: mode %0b len %0d busy %0d done %0d, required %0d and 1",
                    it, m, l, n_busy - b0, n_done - d0, exp_busy(m, l)); end
            vectors++; if (checksum !== ck || error !== (l > 5'd16) || aborted !== 1'b0) begin miscompares++;
                $display("FAIL rand%0d_status: ck %h err %0b ab %0b, required %h %0b 0",
                    it, checksum, error, aborted, ck, l > 5'd16); end
            vectors++; if (n_wr - w0 !== ((l > 5'd16) ? 0 : int'(l))) begin miscompares++;
                $display("FAIL rand%0d_writes: got %0d, len %0d", it, n_wr - w0, l); end
            for (int k = 0; k < DEPTH; k++) begin
                vectors++;
                if (mem[k] !== model_mem[k]) begin miscompares++;
                    $display("FAIL rand%0d_mem[%0d]: got %h, required %h", it, k, mem[k], model_mem[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_wrap_overlap();
        test_len0_error();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_dma.md
Name: ram_dma

Overview:
- Sequencing engine that sits directly upstream of the 16x8 RAM block and drives its read/write port.
- Software or a host FSM issues one command:
  - COPY: block move from src to dst.
  - FILL: write a constant to a range.
- The engine issues the RAM accesses, counts bytes, wraps addresses and returns a done pulse plus an 8-bit checksum of the bytes written.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, cycles from the read-asserted cycle to valid ram_read_data; must be >= 1.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe, sampled only when busy=0.
- mode  in  1  0=COPY, 1=FILL.
- src_addr  in  ADDR_W  COPY source base address.
- dst_addr  in  ADDR_W  destination base address.
- length  in  ADDR_W+1  byte count, 0..2^ADDR_W.
- fill_data  in  DATA_W  FILL pattern.
- abort  in  1  terminate current command.
- busy  out  1  command in progress, including the DONE cycle.
- done  out  1  one-cycle completion pulse.
- error  out  1  last command rejected (length > 2^ADDR_W).
- aborted  out  1  last command terminated by abort.
- checksum  out  DATA_W  mod-2^DATA_W sum of bytes written by the last command.
- ram_read  out  1  RAM read enable.
- ram_write  out  1  RAM write enable.
- ram_read_addr  out  ADDR_W  RAM read address.
- ram_write_addr  out  ADDR_W  RAM write address.
- ram_write_data  out  DATA_W  RAM write data.
- ram_read_data  in  DATA_W  RAM registered read data.

Behaviour:
- Reset (synchronous, active-high, clock edge): state=IDLE.
  - All outputs 0: busy, done, error, aborted, checksum, ram_read, ram_write, both addresses, ram_write_data.
  - Reset wins over start/abort in the same cycle.
  - Reset mid-command stops all RAM strobes from the next cycle; no done pulse.
- States: IDLE, RD, WAIT, WR, DONE.
- All ram_* outputs and busy/done are registered. ram_read=1 only in RD; ram_write=1 only in WR.
- Command acceptance (IDLE, start=1):
  - Latch mode, src, dst, length and fill_data.
  - Clear index i, checksum, error and aborted.
- First state after acceptance:
  - length > 2^ADDR_W: error=1, go to DONE; no RAM access.
  - length=0: go to DONE.
  - FILL: go to WR.
  - COPY: go to RD.
- RD (1 cycle): ram_read_addr = (src+i) mod 2^ADDR_W, then go to WAIT.
- WAIT (RD_LAT cycles): on its last cycle, capture ram_read_data into the data buffer, then go to WR.
- WR (1 cycle):
  - ram_write_addr = (dst+i) mod 2^ADDR_W.
  - ram_write_data = buffer (COPY) or fill_data (FILL).
  - checksum += written byte.
  - i++.
  - If i == length, go to DONE; else go to RD (COPY) or stay in WR (FILL).
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- busy=1 in every state except IDLE. start is ignored while busy=1, including the DONE cycle.
- Cycles with busy=1 after acceptance:
  - COPY: (2+RD_LAT)*L + 1.
  - FILL: L + 1.
  - Length 0 or error: 1.
- Address wrap: src+i and dst+i wrap modulo 2^ADDR_W; no error is raised.
- Overlap: COPY is strictly forward and byte-serial. Each byte is read after all earlier writes, so dst=src+1 replicates mem[src] across the range. This is the required result.
- abort=1 in RD, WAIT or WR: next state DONE with aborted=1.
  - A write already driven in that WR cycle completes and is counted in checksum.
  - No further accesses occur.
  - abort is ignored in IDLE and DONE.
- error, aborted and checksum hold until the next accepted start or reset.

Test Plan:
- Reset with mem preloaded; FILL dst=3 len=4 fill_data=0xA5 -> mem[3..6]=A5, others unchanged; busy high 5 cycles; done one pulse; checksum=0x94.
- COPY src=0 dst=8 len=3 from mem[0..2]={01,02,FF} -> mem[8..10]={01,02,FF}; checksum=0x02; busy high 10 cycles with RD_LAT=1.
- COPY src=14 dst=1 len=4 -> reads 14,15,0,1 and writes 1..4 with wrap. Expected mem[1..4] = {old14, old15, old0, old14}, because address 1 is overwritten before it is read.
- COPY src=2 dst=3 len=3 with mem[2]=0x5C -> mem[3..5]=5C.
- length=0 -> busy and done for exactly 1 cycle, no ram strobes. length=17 -> error=1, done pulse, no strobes.
- abort asserted in the second WR of FILL len=8 -> exactly 2 bytes written, aborted=1, done pulse. A start during busy and a start in the DONE cycle are both ignored. Reset in the WAIT state -> all outputs 0 next cycle, no write.
